fix_checksum_check: RTL and testbench

FIX_CHECKSUM_CHECK -- requirements
Module: fix_checksum_check

---
 rtl/fix_checksum_check.sv | 184 ++++++++++++++++++
 tb/tb_fix_checksum_check.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_checksum_check.sv
// Checks a FIX message's "10=ddd<SOH>" trailer against the modulo-256 byte sum of the preceding bytes.
// Define FIX_CHK_LEN_LIMIT_EN to end messages longer than MAX_LEN bytes with error code 5.
module fix_checksum_check #(
    parameter int MAX_LEN = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ok_o,
    output logic [2:0] err_o,
    output logic [7:0] checksum_o,
    output logic [7:0] rcv_checksum_o
);

    localparam logic [7:0] SOH          = 8'h01;
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MISMATCH = 3'd1;
    localparam logic [2:0] ERR_DIGIT    = 3'd2;
    localparam logic [2:0] ERR_RANGE    = 3'd3;
    localparam logic [2:0] ERR_TERM     = 3'd4;
    localparam logic [2:0] ERR_LEN      = 3'd5;

    typedef enum logic [3:0] {
        IDLE, BODY, SOH_SEEN, TAG1, TAG10, DIG1, DIG2, DIG3, TERM
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] sum, sum_nxt, sum_add;
    logic [7:0] snap, snap_nxt;
    logic [3:0] dig1, dig2, dig3;
    logic [3:0] dig1_nxt, dig2_nxt, dig3_nxt;
    logic [9:0] rcv_value;
    logic       is_digit;
    logic       len_over;
    logic       fin;
    logic [2:0] fin_err;

`ifdef FIX_CHK_LEN_LIMIT_EN
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    logic [15:0] len_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
        end else if (valid_i) begin
            if (start_i)
                len_cnt <= 16'd1;
            else if (state != IDLE)
                len_cnt <= len_cnt + 16'd1;
        end
    end

    assign len_over = (state != IDLE) && (len_cnt >= MAX_LEN_W);
`else
    // Length is unbounded in this build; MAX_LEN has no effect.
    assign len_over = 1'b0 & (MAX_LEN != 0);
`endif

    assign sum_add   = sum + data_i;
    assign is_digit  = (data_i >= 8'h30) && (data_i <= 8'h39);
    assign rcv_value = 10'(dig1) * 10'd100 + 10'(dig2) * 10'd10 + 10'(dig3);
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        snap_nxt  = snap;
        dig1_nxt  = dig1;
        dig2_nxt  = dig2;
        dig3_nxt  = dig3;
        fin       = 1'b0;
        fin_err   = ERR_NONE;

        if (valid_i) begin
            if (start_i) begin
                sum_nxt   = data_i;
                snap_nxt  = (data_i == SOH) ? data_i : 8'h00;
                dig1_nxt  = 4'd0;
                dig2_nxt  = 4'd0;
                dig3_nxt  = 4'd0;
                state_nxt = (data_i == SOH) ? SOH_SEEN : BODY;
            end else if (len_over) begin
                fin     = 1'b1;
                fin_err = ERR_LEN;
            end else begin
                case (state)
                    BODY, SOH_SEEN, TAG1, TAG10: begin
                        sum_nxt = sum_add;
                        if (data_i == SOH) begin
                            snap_nxt  = sum_add;
                            state_nxt = SOH_SEEN;
                        end else if (state == SOH_SEEN && data_i == 8'h31) begin
                            state_nxt = TAG1;
                        end else if (state == TAG1 && data_i == 8'h30) begin
                            state_nxt = TAG10;
                        end else if (state == TAG10 && data_i == 8'h3D) begin
                            state_nxt = DIG1;
                        end else begin
                            state_nxt = BODY;
                        end
                    end
                    DIG1: begin
                        if (is_digit) begin
                            dig1_nxt  = data_i[3:0];
                            state_nxt = DIG2;
                        end else begin
                            fin     = 1'b1;
                            fin_err = ERR_DIGIT;
                        end
                    end
                    DIG2: begin
                        if (is_digit) begin
                            dig2_nxt  = data_i[3:0];
                            state_nxt = DIG3;
                        end else begin
                            fin     = 1'b1;
                            fin_err = ERR_DIGIT;
                        end
                    end
                    DIG3: begin
                        if (is_digit) begin
                            dig3_nxt  = data_i[3:0];
                            state_nxt = TERM;
                        end else begin
                            fin     = 1'b1;
                            fin_err = ERR_DIGIT;
                        end
                    end
                    TERM: begin
                        fin = 1'b1;
                        if (data_i != SOH)
                            fin_err = ERR_TERM;
                        else if (rcv_value > 10'd255)
                            fin_err = ERR_RANGE;
                        else if (rcv_value[7:0] != snap)
                            fin_err = ERR_MISMATCH;
                        else
                            fin_err = ERR_NONE;
                    end
                    default: ;
                endcase
            end
        end

        if (fin)
            state_nxt = IDLE;
    end

    // Result outputs only move on completion and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sum            <= '0;
            snap           <= '0;
            dig1           <= '0;
            dig2           <= '0;
            dig3           <= '0;
            done_o         <= 1'b0;
            ok_o           <= 1'b0;
            err_o          <= '0;
            checksum_o     <= '0;
            rcv_checksum_o <= '0;
        end else begin
            state  <= state_nxt;
            sum    <= sum_nxt;
            snap   <= snap_nxt;
            dig1   <= dig1_nxt;
            dig2   <= dig2_nxt;
            dig3   <= dig3_nxt;
            done_o <= fin;
            if (fin) begin
                ok_o           <= (fin_err == ERR_NONE);
                err_o          <= fin_err;
                checksum_o     <= snap;
                rcv_checksum_o <= rcv_value[7:0];
            end
        end
    end

endmodule

// File: tb/tb_fix_checksum_check.sv
// Directed self-checking bench for fix_checksum_check; expected results are hand-computed byte sums.
module tb_fix_checksum_check;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       ok_o;
    logic [2:0] err_o;
    logic [7:0] checksum_o;
    logic [7:0] rcv_checksum_o;

    int checks;
    int errors;
    int early_done;
    logic [8:0]  tx_q[$];
    logic [20:0] got;

    fix_checksum_check #(.MAX_LEN(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ok_o           (ok_o),
        .err_o          (err_o),
        .checksum_o     (checksum_o),
        .rcv_checksum_o (rcv_checksum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic q_byte(input logic [7:0] b, input logic st);
        tx_q.push_back({st, b});
    endtask

    task automatic q_str(input string s);
        for (int i = 0; i < s.len(); i++)
            tx_q.push_back({1'b0, s[i]});
    endtask

    // Drives the queued bytes on negedges; after return done_o reflects the last byte.
    task automatic send_q(input int gap);
        early_done = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge clk);
            if (done_o) early_done++;
            data_i  = tx_q[i][7:0];
            start_i = tx_q[i][8];
            valid_i = 1'b1;
            if (i < tx_q.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    if (done_o) early_done++;
                    valid_i = 1'b0;
                    start_i = 1'b1;
                    data_i  = 8'h01;
                end
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        start_i = 1'b0;
        data_i  = 8'h00;
        tx_q.delete();
        got = {done_o, ok_o, err_o, checksum_o, rcv_checksum_o};
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_i = 1'b0;
        start_i = 1'b0;
        data_i  = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, done_o, ok_o, err_o, checksum_o, rcv_checksum_o} !== 22'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h want 0",
                     {busy_o, done_o, ok_o, err_o, checksum_o, rcv_checksum_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=066"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (early_done !== 0) begin
            errors++;
            $display("[TB] FAIL nominal_early_done: got %0d want 0", early_done);
        end
        checks++;
        if (got !== {1'b1, 1'b1, 3'd0, 8'h42, 8'h42}) begin
            errors++;
            $display("[TB] FAIL nominal_result: got %h want %h", got, {1'b1, 1'b1, 3'd0, 8'h42, 8'h42});
        end
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, ok_o, err_o, checksum_o} !== {1'b0, 1'b0, 1'b1, 3'd0, 8'h42}) begin
            errors++;
            $display("[TB] FAIL nominal_pulse_hold: got %h want %h",
                     {busy_o, done_o, ok_o, err_o, checksum_o}, {1'b0, 1'b0, 1'b1, 3'd0, 8'h42});
        end
    endtask

    task automatic test_mismatch();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=067"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b0, 3'd1, 8'h42, 8'h43}) begin
            errors++;
            $display("[TB] FAIL mismatch_result: got %h want %h", got, {1'b1, 1'b0, 3'd1, 8'h42, 8'h43});
        end
    endtask

    task automatic test_wrap_false_tag();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("102=B"); q_byte(8'h01, 1'b0);
        q_str("10=085"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b1, 3'd0, 8'h55, 8'h55}) begin
            errors++;
            $display("[TB] FAIL wrap_result: got %h want %h", got, {1'b1, 1'b1, 3'd0, 8'h55, 8'h55});
        end
    endtask

    task automatic test_bad_digit();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=2a");
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b0, 3'd2, 8'h42, 8'hC8}) begin
            errors++;
            $display("[TB] FAIL bad_digit_result: got %h want %h", got, {1'b1, 1'b0, 3'd2, 8'h42, 8'hC8});
        end
    endtask

    task automatic test_range();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=300"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b0, 3'd3, 8'h42, 8'h2C}) begin
            errors++;
            $display("[TB] FAIL range_result: got %h want %h", got, {1'b1, 1'b0, 3'd3, 8'h42, 8'h2C});
        end
    endtask

    task automatic test_terminator();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=066X");
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b0, 3'd4, 8'h42, 8'h42}) begin
            errors++;
            $display("[TB] FAIL terminator_result: got %h want %h", got, {1'b1, 1'b0, 3'd4, 8'h42, 8'h42});
        end
    endtask

    task automatic test_idle_gaps();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=066"); q_byte(8'h01, 1'b0);
        send_q(2);
        checks++;
        if (early_done !== 0) begin
            errors++;
            $display("[TB] FAIL gaps_early_done: got %0d want 0", early_done);
        end
        checks++;
        if (got !== {1'b1, 1'b1, 3'd0, 8'h42, 8'h42}) begin
            errors++;
            $display("[TB] FAIL gaps_result: got %h want %h", got, {1'b1, 1'b1, 3'd0, 8'h42, 8'h42});
        end
    endtask

    task automatic test_abort();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=0");
        q_byte(8'h43, 1'b1); q_byte(8'h01, 1'b0); q_str("10=068"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (early_done !== 0) begin
            errors++;
            $display("[TB] FAIL abort_early_done: got %0d want 0", early_done);
        end
        checks++;
        if (got !== {1'b1, 1'b1, 3'd0, 8'h44, 8'h44}) begin
            errors++;
            $display("[TB] FAIL abort_result: got %h want %h", got, {1'b1, 1'b1, 3'd0, 8'h44, 8'h44});
        end
    endtask

    task automatic test_back_to_back();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=067"); q_byte(8'h01, 1'b0);
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=066"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (early_done !== 1) begin
            errors++;
            $display("[TB] FAIL b2b_first_done: got %0d want 1", early_done);
        end
        checks++;
        if (got !== {1'b1, 1'b1, 3'd0, 8'h42, 8'h42}) begin
            errors++;
            $display("[TB] FAIL b2b_result: got %h want %h", got, {1'b1, 1'b1, 3'd0, 8'h42, 8'h42});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done_o, ok_o, err_o, checksum_o, rcv_checksum_o} !== {1'b0, 1'b1, 3'd0, 8'h42, 8'h42}) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got %h want %h",
                     {done_o, ok_o, err_o, checksum_o, rcv_checksum_o}, {1'b0, 1'b1, 3'd0, 8'h42, 8'h42});
        end
    endtask

    task automatic test_reset_mid();
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=0");
        send_q(0);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy: got %b want 1", busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, ok_o, err_o, checksum_o, rcv_checksum_o} !== 22'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: got %h want 0",
                     {busy_o, done_o, ok_o, err_o, checksum_o, rcv_checksum_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        q_byte(8'h41, 1'b1); q_byte(8'h01, 1'b0); q_str("10=066"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b1, 3'd0, 8'h42, 8'h42}) begin
            errors++;
            $display("[TB] FAIL post_reset_result: got %h want %h", got, {1'b1, 1'b1, 3'd0, 8'h42, 8'h42});
        end
    endtask

    task automatic test_length();
`ifdef FIX_CHK_LEN_LIMIT_EN
        q_byte(8'h41, 1'b1); q_str("B"); q_byte(8'h01, 1'b0); q_str("10=132");
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b0, 3'd5, 8'h84, 8'h82}) begin
            errors++;
            $display("[TB] FAIL length_limit: got %h want %h", got, {1'b1, 1'b0, 3'd5, 8'h84, 8'h82});
        end
`else
        q_byte(8'h41, 1'b1); q_str("B"); q_byte(8'h01, 1'b0); q_str("10=132"); q_byte(8'h01, 1'b0);
        send_q(0);
        checks++;
        if (got !== {1'b1, 1'b1, 3'd0, 8'h84, 8'h84}) begin
            errors++;
            $display("[TB] FAIL length_unbounded: got %h want %h", got, {1'b1, 1'b1, 3'd0, 8'h84, 8'h84});
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_nominal();
        test_mismatch();
        test_wrap_false_tag();
        test_bad_digit();
        test_range();
        test_terminator();
        test_idle_gaps();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_length();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
